// File: rtl/fp_conv_pkg.sv
// Shared constants and state encoding for the fixed-to-float converter.
package fp_conv_pkg;
  localparam int FP32_EXP_BIAS = 127;
  localparam int FP32_MANT_W   = 23;
  localparam int FP32_EXP_W    = 8;
  localparam int FIX_FRAC_W    = 20;
  localparam int FIX_W         = 22;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_PACK = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    NORM = ST_NORM,
    PACK = ST_PACK
  } state_t;
endpackage

// File: rtl/lzc_21.sv
// Combinational leading-zero counter over a 21-bit vector; all-zero input yields 21.
module lzc_21 (
  input  logic [20:0] in_vec,
  output logic [4:0]  count
);
  // Scan from LSB up so the highest set bit sets the final count
  always_comb begin
    count = 5'd21;
    for (int i = 0; i < 21; i++) begin
      if (in_vec[i]) count = 5'(20 - i);
    end
  end
endmodule

// File: rtl/fixed_float_converter.sv
// Sign-magnitude fixed point {sign, int, frac} -> IEEE-754 single precision.
// IDLE -> NORM -> PACK -> IDLE. NORM shifts the magnitude left until the
// integer bit is set, counting shifts to derive the exponent.
// Build option FAST_NORM_EN: NORM resolves in one cycle via lzc_21
// (assumes FRAC_W = 20 so the magnitude is 21 bits wide).
module fixed_float_converter
  import fp_conv_pkg::*;
#(
  parameter int FRAC_W   = FIX_FRAC_W,
  parameter int EXP_BIAS = FP32_EXP_BIAS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [FRAC_W+1:0] data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result
);
  localparam int MW = FRAC_W + 1;

  state_t          state, state_nx;
  logic            sign_q;
  logic [MW-1:0]   mag_q, mag_nx;
  logic [4:0]      cnt_q, cnt_nx;
  logic [FP32_MANT_W-1:0] mant;
  logic [FP32_EXP_W-1:0]  exp_v;
  logic [31:0]     pack_res;

`ifdef FAST_NORM_EN
  logic [4:0] lz;
  lzc_21 u_lzc (.in_vec(mag_q), .count(lz));
`endif

  assign busy = (state != IDLE);

  // Next-state, normalisation shift and shift count
  always_comb begin
    state_nx = state;
    mag_nx   = mag_q;
    cnt_nx   = cnt_q;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nx = NORM;
          mag_nx   = data[MW-1:0];
          cnt_nx   = 5'd0;
        end
      end
      NORM: begin
`ifdef FAST_NORM_EN
        // Zero stays zero; otherwise one full shift lands the leading one on the integer bit
        if (mag_q != '0) begin
          mag_nx = mag_q << lz;
          cnt_nx = lz;
        end
        state_nx = PACK;
`else
        if (mag_q == '0 || mag_q[FRAC_W]) begin
          state_nx = PACK;
        end else begin
          mag_nx = mag_q << 1;
          cnt_nx = cnt_q + 5'd1;
        end
`endif
      end
      PACK:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result assembly; zero magnitude always packs to +0
  always_comb begin
    mant = '0;
    mant[FP32_MANT_W-1 -: FRAC_W] = mag_q[FRAC_W-1:0];
    exp_v = FP32_EXP_W'(EXP_BIAS) - {3'b000, cnt_q};
    pack_res = (mag_q == '0) ? 32'h0 : {sign_q, exp_v, mant};
  end

  // State, datapath and output registers; reset aborts any conversion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sign_q <= 1'b0;
      mag_q  <= '0;
      cnt_q  <= 5'd0;
      done   <= 1'b0;
      result <= 32'h0;
    end else begin
      state <= state_nx;
      mag_q <= mag_nx;
      cnt_q <= cnt_nx;
      done  <= (state == PACK);
      if (state == IDLE && enable) sign_q <= data[MW];
      if (state == PACK) result <= pack_res;
    end
  end
endmodule

// File: tb/tb_fixed_float_converter.sv
// Scoreboard bench: stimulus pushes expected {result, latency}, monitor pops on done.
module tb_fixed_float_converter;
  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [21:0] data;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dones = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          cap;
  } exp_t;
  exp_t q[$];

  fixed_float_converter dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data(data),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: real-valued magnitude -> double bits -> repack as single
  function automatic logic [31:0] ref_res(input logic [21:0] d);
    real         v;
    logic [63:0] b;
    if (d[20:0] == 21'd0) return 32'h0;
    v = $itor(d[20:0]) / 1048576.0;
    b = $realtobits(v);
    return {d[21], 8'(b[62:52] - 11'd896), b[51:29]};
  endfunction

  function automatic int ref_lat(input logic [21:0] d);
`ifdef FAST_NORM_EN
    return 2;
`else
    int m;
    m = int'(d[20:0]);
    if (m == 0) return 2;
    return (21 - $clog2(m + 1)) + 2;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Waits for IDLE, presents one request for one edge, then scrambles data
  task automatic issue(input logic [21:0] d);
    int w;
    exp_t e;
    w = 0;
    while (busy && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) begin
      total++; bad++;
      $display("FAIL issue_timeout: busy stuck, wanted idle");
    end
    enable = 1'b1;
    data   = d;
    e.res = ref_res(d);
    e.lat = ref_lat(d);
    e.cap = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    enable = 1'b0;
    data   = 22'($urandom);
  endtask

  // Monitor: compare on every done pulse
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n && done) begin
      dones++;
      if (prev_done) begin
        total++; bad++;
        $display("FAIL done_width: done high two cycles, wanted one");
      end
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: result %h with empty scoreboard", result);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("latency", 32'(cyc - e.cap), 32'(e.lat));
      end
    end
    prev_done <= done;
  end

  logic [21:0] dirs[7] = '{22'h100000, 22'h080000, 22'h300000, 22'h000001,
                           22'h1FFFFF, 22'h200000, 22'h000000};

  initial begin
    int w;
    int d0;
    rst_n = 1'b0; enable = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed points incl. zero, -0, extremes
    for (int i = 0; i < 7; i++) issue(dirs[i]);

    // enable re-pulsed with other data mid-conversion must be ignored
    issue(22'h000001);
    repeat (3) begin
      enable = 1'b1; data = 22'h3ABCDE;
      @(negedge clk);
    end
    enable = 1'b0;

    // Random sweep with varied leading-zero counts
    for (int i = 0; i < 2000; i++)
      issue(22'($urandom) >> $urandom_range(0, 21));

    w = 0;
    while (q.size() != 0 && w < 200) begin @(negedge clk); w++; end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d results outstanding, wanted 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);

    // Reset mid-NORM: abort, clear outputs, no late done
    issue(22'h000001);
    repeat (4) @(negedge clk);
    q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'h0);
    rst_n = 1'b1;
    d0 = dones;
    repeat (30) @(negedge clk);
    chk("no_done_after_rst", 32'(dones), 32'(d0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
